// File: rtl/axis_gpio_tx.sv
// axis_gpio_tx: samples GPIO inputs and sends a fixed-format byte frame on an
// 8-bit AXI-Stream master. The frame holds the GPIO state as ASCII '0'/'1'
// characters at byte offset BYTE_START (MSB first), so a looped-back frame
// drives the companion LED receiver to the switch state.
//
// Ports:
//   clk           single clock
//   reset_n       asynchronous active-low reset
//   gpio_in       raw asynchronous switch inputs
//   send_req      single-cycle request to send a frame regardless of change
//   m_axis_data   stream byte
//   m_axis_valid  byte valid
//   m_axis_last   high on the final (TERM_VALUE) byte
//   m_axis_ready  downstream accept
//   busy          high while a frame is in flight
//   frame_cnt     completed frames, wraps at 16 bits
module axis_gpio_tx #(
  parameter int unsigned BYTE_START = 32,
  parameter int unsigned GPIO_WIDTH = 2,
  parameter int unsigned AXI_WIDTH  = 8,    // only 8 is supported
  parameter logic [7:0]  PAD_VALUE  = 8'h00,
  parameter logic [7:0]  TERM_VALUE = 8'h0A
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  input  logic                  send_req,
  output logic [AXI_WIDTH-1:0]  m_axis_data,
  output logic                  m_axis_valid,
  output logic                  m_axis_last,
  input  logic                  m_axis_ready,
  output logic                  busy,
  output logic [15:0]           frame_cnt
);

  localparam int unsigned FRAME_LEN = BYTE_START + GPIO_WIDTH + 1;
  localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                 state_q, state_d;
  logic [GPIO_WIDTH-1:0]  sync1_q, sync2_q;
  logic [GPIO_WIDTH-1:0]  snapshot_q, snapshot_d;
  logic [GPIO_WIDTH-1:0]  last_sent_q, last_sent_d;
  logic                   req_pending_q, req_pending_d;
  logic [IDX_W-1:0]       idx_q, idx_d, idx_nxt;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   start;

  // Byte content at a given frame index for a given GPIO snapshot.
  function automatic logic [7:0] byte_at(input logic [IDX_W-1:0]      idx,
                                         input logic [GPIO_WIDTH-1:0] snap);
    int unsigned           i;
    logic [GPIO_WIDTH-1:0] shifted;
    i = 32'(idx);
    // Only meaningful inside the ASCII field; out-of-range shifts are unused.
    shifted = snap >> (GPIO_WIDTH - 1 - (i - BYTE_START));
    if (i < BYTE_START) begin
      byte_at = PAD_VALUE;
    end else if (i < BYTE_START + GPIO_WIDTH) begin
      byte_at = shifted[0] ? 8'h31 : 8'h30;
    end else begin
      byte_at = TERM_VALUE;
    end
  endfunction

  // Pending request, live request, or an unsent GPIO change starts a frame.
  assign start   = (sync2_q != last_sent_q) || req_pending_q || send_req;
  assign idx_nxt = idx_q + IDX_W'(1);

  always_comb begin
    state_d       = state_q;
    snapshot_d    = snapshot_q;
    last_sent_d   = last_sent_q;
    req_pending_d = req_pending_q | send_req;
    idx_d         = idx_q;
    data_d        = data_q;
    valid_d       = valid_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d       = StSend;
          snapshot_d    = sync2_q;
          last_sent_d   = sync2_q;
          req_pending_d = 1'b0;   // also swallows a send_req on this edge
          idx_d         = '0;
          data_d        = byte_at('0, sync2_q);
          last_d        = (LAST_IDX == '0);
          valid_d       = 1'b1;
        end
      end
      StSend: begin
        if (valid_q && m_axis_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = StIdle;
            valid_d = 1'b0;
            last_d  = 1'b0;
            cnt_d   = cnt_q + 16'd1;
          end else begin
            idx_d  = idx_nxt;
            data_d = byte_at(idx_nxt, snapshot_q);
            last_d = (idx_nxt == LAST_IDX);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      sync1_q       <= '0;
      sync2_q       <= '0;
      snapshot_q    <= '0;
      last_sent_q   <= '0;
      req_pending_q <= 1'b0;
      idx_q         <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= gpio_in;
      sync2_q       <= sync1_q;
      snapshot_q    <= snapshot_d;
      last_sent_q   <= last_sent_d;
      req_pending_q <= req_pending_d;
      idx_q         <= idx_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
    end
  end

  assign m_axis_data  = data_q;
  assign m_axis_valid = valid_q;
  assign m_axis_last  = last_q;
  assign busy         = (state_q == StSend);
  assign frame_cnt    = cnt_q;

endmodule

// File: tb/tb_axis_gpio_tx.sv
module tb_axis_gpio_tx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  gpio_in = 2'b00;
  logic        send_req = 1'b0;
  logic        m_axis_ready = 1'b1;
  logic [7:0]  m_axis_data;
  logic        m_axis_valid;
  logic        m_axis_last;
  logic        busy;
  logic [15:0] frame_cnt;

  int nvec = 0;
  int nerr = 0;
  int exp_frames = 0;
  bit rand_ready = 1'b0;

  // {last, data}
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];

  axis_gpio_tx dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .gpio_in      (gpio_in),
    .send_req     (send_req),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_last  (m_axis_last),
    .m_axis_ready (m_axis_ready),
    .busy         (busy),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    m_axis_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Records handshakes and checks AXI-Stream hold and inter-frame idle rules.
  logic       stall_prev = 1'b0;
  logic       last_hs = 1'b0;
  logic [8:0] held = '0;
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
      last_hs    = 1'b0;
    end else begin
      if (stall_prev) begin
        nvec++;
        if (m_axis_valid !== 1'b1 || {m_axis_last, m_axis_data} !== held) begin
          nerr++;
          $display("FAIL stall_hold: got valid=%b last/data=%h, want valid=1 last/data=%h",
                   m_axis_valid, {m_axis_last, m_axis_data}, held);
        end
      end
      if (last_hs) begin
        nvec++;
        if (m_axis_valid !== 1'b0) begin
          nerr++;
          $display("FAIL idle_gap: got valid=%b after last byte, want 0", m_axis_valid);
        end
      end
      if (m_axis_valid && m_axis_ready) obs_q.push_back({m_axis_last, m_axis_data});
      stall_prev = m_axis_valid && !m_axis_ready;
      held       = {m_axis_last, m_axis_data};
      last_hs    = m_axis_valid && m_axis_ready && m_axis_last;
    end
  end

  // Expected frame: 32 pads, ASCII g[1], g[0], terminator with last.
  function automatic void push_frame(input logic [1:0] g);
    logic [7:0] d;
    for (int i = 0; i < 35; i++) begin
      if (i < 32)      d = 8'h00;
      else if (i < 34) d = g[33 - i] ? 8'h31 : 8'h30;
      else             d = 8'h0A;
      exp_q.push_back({(i == 34), d});
    end
  endfunction

  task automatic wait_obs(input int n, input int budget, output bit ok);
    int c = 0;
    while (obs_q.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    ok = (obs_q.size() >= n);
  endtask

  task automatic pulse_req();
    @(posedge clk); #1 send_req = 1'b1;
    @(posedge clk); #1 send_req = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    #2 reset_n = 1'b0;
    #1;
    nvec++;
    if ({m_axis_valid, m_axis_last, busy, frame_cnt, m_axis_data} !== 27'd0) begin
      nerr++;
      $display("FAIL reset_outputs: got v=%b l=%b b=%b cnt=%h d=%h, want all 0",
               m_axis_valid, m_axis_last, busy, frame_cnt, m_axis_data);
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    wait_obs(1, 50, ok);
    nvec++;
    if (ok || m_axis_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd0) begin
      nerr++;
      $display("FAIL reset_quiet: got bytes=%0d v=%b b=%b cnt=%0d, want 0 0 0 0",
               obs_q.size(), m_axis_valid, busy, frame_cnt);
    end
  endtask

  task automatic test_change();
    bit ok;
    logic [8:0] e, g;
    int k = 0;
    @(posedge clk); #1 gpio_in = 2'b10;
    @(posedge clk); @(posedge clk); #1;
    nvec++;
    if (m_axis_valid !== 1'b0) begin
      nerr++; $display("FAIL change_early: got valid=%b after 2 edges, want 0", m_axis_valid);
    end
    @(posedge clk); #1;
    nvec++;
    if (m_axis_valid !== 1'b1 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL change_latency: got valid=%b busy=%b after 3 edges, want 1 1",
               m_axis_valid, busy);
    end
    push_frame(2'b10);
    exp_frames++;
    wait_obs(exp_q.size(), 100, ok);
    nvec++;
    if (!ok) begin
      nerr++; $display("FAIL change_timeout: got %0d bytes, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (obs_q.size() != 0) ? obs_q.pop_front() : 9'bx;
      nvec++;
      if (g !== e) begin
        nerr++; $display("FAIL change_byte%0d: got %h, want %h", k, g, e);
      end
      k++;
    end
    nvec++;
    if (frame_cnt !== 16'(exp_frames)) begin
      nerr++; $display("FAIL change_cnt: got %0d, want %0d", frame_cnt, exp_frames);
    end
    wait_obs(1, 30, ok);
    nvec++;
    if (ok || busy !== 1'b0) begin
      nerr++; $display("FAIL change_no_second: got bytes=%0d busy=%b, want 0 0", obs_q.size(), busy);
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [8:0] e, g;
    int k = 0;
    rand_ready = 1'b1;
    pulse_req();
    push_frame(2'b10);
    exp_frames++;
    wait_obs(exp_q.size(), 600, ok);
    nvec++;
    if (!ok) begin
      nerr++; $display("FAIL stall_timeout: got %0d bytes, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (obs_q.size() != 0) ? obs_q.pop_front() : 9'bx;
      nvec++;
      if (g !== e) begin
        nerr++; $display("FAIL stall_byte%0d: got %h, want %h", k, g, e);
      end
      k++;
    end
    rand_ready = 1'b0;
    wait_obs(1, 20, ok);
    nvec++;
    if (ok || frame_cnt !== 16'(exp_frames)) begin
      nerr++;
      $display("FAIL stall_count: got extra=%0d cnt=%0d, want 0 %0d",
               obs_q.size(), frame_cnt, exp_frames);
    end
  endtask

  task automatic test_mid_change();
    bit ok;
    logic [8:0] e, g;
    int k = 0;
    @(posedge clk); #1 gpio_in = 2'b01;
    push_frame(2'b01);
    push_frame(2'b11);
    exp_frames += 2;
    wait_obs(5, 40, ok);
    gpio_in = 2'b11;
    wait_obs(exp_q.size(), 200, ok);
    nvec++;
    if (!ok) begin
      nerr++; $display("FAIL mid_timeout: got %0d bytes, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (obs_q.size() != 0) ? obs_q.pop_front() : 9'bx;
      nvec++;
      if (g !== e) begin
        nerr++; $display("FAIL mid_byte%0d: got %h, want %h", k, g, e);
      end
      k++;
    end
    nvec++;
    if (frame_cnt !== 16'(exp_frames)) begin
      nerr++; $display("FAIL mid_cnt: got %0d, want %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_req_coalesce();
    bit ok;
    logic [8:0] e, g;
    int k = 0;
    pulse_req();   // starts the frame on the same edge, so it is consumed
    nvec++;
    if (busy !== 1'b1) begin
      nerr++; $display("FAIL req_start: got busy=%b, want 1", busy);
    end
    repeat (3) @(posedge clk);
    pulse_req();
    repeat (5) @(posedge clk);
    pulse_req();
    push_frame(2'b11);
    push_frame(2'b11);
    exp_frames += 2;
    wait_obs(exp_q.size() - (k), 200, ok);
    nvec++;
    if (!ok) begin
      nerr++; $display("FAIL req_timeout: got %0d bytes, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (obs_q.size() != 0) ? obs_q.pop_front() : 9'bx;
      nvec++;
      if (g !== e) begin
        nerr++; $display("FAIL req_byte%0d: got %h, want %h", k, g, e);
      end
      k++;
    end
    wait_obs(1, 60, ok);
    nvec++;
    if (ok || frame_cnt !== 16'(exp_frames)) begin
      nerr++;
      $display("FAIL req_coalesce: got extra=%0d cnt=%0d, want 0 %0d",
               obs_q.size(), frame_cnt, exp_frames);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [8:0] e, g;
    int k = 0;
    pulse_req();
    wait_obs(20, 60, ok);
    reset_n = 1'b0;
    #1;
    nvec++;
    if ({m_axis_valid, m_axis_last, busy} !== 3'b000 || frame_cnt !== 16'd0) begin
      nerr++;
      $display("FAIL rst_mid_drop: got v=%b l=%b b=%b cnt=%0d, want 0 0 0 0",
               m_axis_valid, m_axis_last, busy, frame_cnt);
    end
    exp_frames = 0;
    obs_q.delete();
    exp_q.delete();
    gpio_in = 2'b01;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    push_frame(2'b01);
    exp_frames++;
    wait_obs(exp_q.size(), 100, ok);
    nvec++;
    if (!ok) begin
      nerr++; $display("FAIL rst_mid_timeout: got %0d bytes, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (obs_q.size() != 0) ? obs_q.pop_front() : 9'bx;
      nvec++;
      if (g !== e) begin
        nerr++; $display("FAIL rst_mid_byte%0d: got %h, want %h", k, g, e);
      end
      k++;
    end
    nvec++;
    if (frame_cnt !== 16'(exp_frames)) begin
      nerr++; $display("FAIL rst_mid_cnt: got %0d, want %0d", frame_cnt, exp_frames);
    end
  endtask

  initial begin
    test_reset();
    test_change();
    test_stall();
    test_mid_change();
    test_req_coalesce();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
